// File: rtl/equalizer_i2s_tx_pkg.sv
// Shared definitions for the equalizer I2S transmitter (and a future receiver).
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package equalizer_i2s_tx_pkg;

    // Word-select encoding on lrclk: left channel while low, right while high.
    typedef enum logic {
        LR_LEFT  = 1'b0,
        LR_RIGHT = 1'b1
    } lr_sel_e;

    // One stereo frame carries two channel slots of sample_bits bit clocks each.
    function automatic int frame_slots(input int sample_bits);
        return 2 * sample_bits;
    endfunction

    // Counter width that stays legal for a modulus of 1.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/equalizer_i2s_tx_fifo.sv
// Single-clock sample FIFO, depth 2^ADDR_BITS, head readable combinationally.
// Latency: level/empty/full update the cycle after a push or pop; dout is the current head.
// Backpressure: push while full is ignored unless a pop frees the head slot in the same cycle.
//
// Ports: clk, rst (async active-high), clear (sync flush), push/din, pop/dout,
//        full, empty, level (entries stored, ADDR_BITS+1 bits).
module sample_fifo #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   level
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr;
    logic [ADDR_BITS:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                   (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[ADDR_BITS-1:0]];

    // When full, a same-cycle pop releases the head slot, which is exactly
    // where the write pointer points, so the push can land there.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_BITS-1:0]] <= din;
    end

endmodule

// File: rtl/equalizer_i2s_tx.sv
// Equalizer output transmitter: buffers filter_out samples and sends them as stereo I2S (mono duplicated).
// Latency: sample_valid to left MSB on sdata is the wait to the next frame load plus one register stage.
// Backpressure: none upstream; a sample arriving at a full FIFO is dropped and flags overflow.
//
// Ports: clk, rst (async active-high), tx_enable (sync run/flush), sample_valid/sample_in (capture strobe
//        and data), clear_flags (sync flag clear), bclk/lrclk/sdata (I2S out), fifo_level, underflow, overflow.
module equalizer_i2s_tx
    import equalizer_i2s_tx_pkg::*;
#(
    parameter int SAMPLE_BITS    = 16,
    parameter int BCLK_DIV       = 1,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_enable,
    input  logic                      sample_valid,
    input  logic [SAMPLE_BITS-1:0]    sample_in,
    input  logic                      clear_flags,
    output logic                      bclk,
    output logic                      lrclk,
    output logic                      sdata,
    output logic [FIFO_ADDR_BITS:0]   fifo_level,
    output logic                      underflow,
    output logic                      overflow
);

    localparam int FRAME_SLOTS = frame_slots(SAMPLE_BITS);
    localparam int SLOT_W      = cnt_width(FRAME_SLOTS);
    localparam int DIV_W       = cnt_width(BCLK_DIV);

    logic [DIV_W-1:0]        div_cnt;
    logic [SLOT_W-1:0]       slot;
    logic [SLOT_W-1:0]       next_slot;
    logic [FRAME_SLOTS-1:0]  shreg;
    logic                    bclk_q;
    lr_sel_e                 lrclk_q;
    logic                    underflow_q;
    logic                    overflow_q;

    logic                    div_wrap;
    logic                    fall_evt;
    logic                    load_evt;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [SAMPLE_BITS-1:0]  fifo_dout;
    logic                    overflow_evt;
    logic                    underflow_evt;

    assign div_wrap  = (div_cnt == DIV_W'(BCLK_DIV - 1));
    // bclk is about to go 1->0: this is where slot, lrclk and data all move.
    assign fall_evt  = div_wrap && bclk_q;
    assign load_evt  = fall_evt && (slot == '0);
    assign next_slot = (slot == SLOT_W'(FRAME_SLOTS - 1)) ? '0 : slot + 1'b1;

    assign fifo_pop      = load_evt && !fifo_empty;
    assign underflow_evt = load_evt && fifo_empty;
    // A pop in the same cycle makes room, so only a pop-less push to a full FIFO is lost.
    assign overflow_evt  = tx_enable && sample_valid && fifo_full && !fifo_pop;

    sample_fifo #(
        .WIDTH     (SAMPLE_BITS),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (!tx_enable),
        .push  (tx_enable && sample_valid),
        .pop   (fifo_pop),
        .din   (sample_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            slot        <= '0;
            shreg       <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= LR_LEFT;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (!tx_enable) begin
            div_cnt     <= '0;
            slot        <= '0;
            shreg       <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= LR_LEFT;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                bclk_q  <= !bclk_q;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (fall_evt) begin
                slot    <= next_slot;
                lrclk_q <= (next_slot >= SLOT_W'(SAMPLE_BITS)) ? LR_RIGHT : LR_LEFT;
                if (slot == '0) begin
                    // Slot 0 still shows the previous right LSB; the new word's MSB
                    // appears in slot 1, giving the one-bit I2S delay.
                    shreg <= fifo_empty ? '0 : {fifo_dout, fifo_dout};
                end else begin
                    shreg <= {shreg[FRAME_SLOTS-2:0], 1'b0};
                end
            end

            // A new event outranks a simultaneous clear.
            if (underflow_evt)    underflow_q <= 1'b1;
            else if (clear_flags) underflow_q <= 1'b0;

            if (overflow_evt)     overflow_q <= 1'b1;
            else if (clear_flags) overflow_q <= 1'b0;
        end
    end

    assign bclk      = bclk_q;
    assign lrclk     = lrclk_q;
    assign sdata     = shreg[FRAME_SLOTS-1];
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule
